arch_maptable: RTL and testbench
================================

ARCH_MAPTABLE -- requirements
Module: arch_maptable

Interface
REQ-001 Parameters (from shared defines): SUPERSCALAR_WAYS, default 3, retire width; N_ARCH_REG, default 32, architectural registers; N_PHYS_REG_BITS, default 6, physical tag width; ZERO_REG, default 31, hardwired-zero architectural index.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 retire_in  input  SUPERSCALAR_WAYS x RETIRE_MAPTABLE_PACKET  per retire way: enable, ar_idx, t_idx (new tag), told_idx (previous tag); way 0 is oldest.
REQ-005 recovery_maptable  output  MAPTABLE_PACKET  committed map and done bits, consumed by the rename map table on branch recovery.
REQ-006 freelist_out  output  SUPERSCALAR_WAYS x FREED_REG_PACKET  per way: valid, pr_idx of the physical register released to the free list.
REQ-007 told_mismatch  output  1  sticky error flag: a retiring told_idx disagreed with the committed mapping.

Function
REQ-008 State: map, N_ARCH_REG x N_PHYS_REG_BITS committed mapping; told_mismatch register.
REQ-009 A way is active iff enable is set and ar_idx != ZERO_REG; inactive ways cause no map update and no free.
REQ-010 Each active way i writes map[ar_idx] <= t_idx at the next rising edge.
REQ-011 Several active ways with the same ar_idx in one cycle: the youngest (highest-index) way's t_idx wins.
REQ-012 recovery_maptable.map is combinational next-state: committed map with all active writes of the current cycle applied, so a branch retiring on way k with br_recover_enable in the same cycle recovers to a map that includes ways 0..k.
REQ-013 recovery_maptable.done is all ones at all times.
REQ-014 freelist_out[i].valid equals way i active; freelist_out[i].pr_idx equals retire_in[i].told_idx; both combinational, same cycle as retire.
REQ-015 Expected told for active way i: t_idx of the youngest older active way j<i with the same ar_idx if one exists, else committed map[ar_idx].
REQ-016 Any active way whose told_idx differs from its expected told sets told_mismatch at the next edge; it stays set until reset.
REQ-017 Retiring ways need not be contiguous; an inactive way between active ways is skipped with no effect on bypass order.
REQ-018 No handshake: the ROB guarantees retire order; the block accepts all ways every cycle without backpressure.

Reset
REQ-019 On reset, map[i] <= i for every i, and told_mismatch <= 0.
REQ-020 Reset has priority over simultaneous retires; retires in the reset cycle are discarded.
REQ-021 During the reset cycle, freelist_out valids are forced to 0 and recovery_maptable.map shows the identity mapping.

Structure
REQ-022 RETIRE_MAPTABLE_PACKET and FREED_REG_PACKET belong in the shared system-defines package; MAPTABLE_PACKET is reused unchanged.
REQ-023 A single flat module with no sub-modules; next-map generation and told-bypass checking are separate always_comb blocks.

Verification
REQ-024 Reset -> recovery_maptable.map[i]==i for all i, all done bits 1, told_mismatch 0, no freelist valids.
REQ-025 Retire way0 {ar 5, t 40, told 5} -> same cycle freelist_out[0]={1,5} and recovery map[5]==40; next cycle committed map[5]==40.
REQ-026 Same cycle, ways 0/1/2 all ar 3: t 33/34/35, told 3/33/34 -> map[3]==35, frees 3,33,34, told_mismatch stays 0.
REQ-027 Retire way1 {ar 31, t 50} -> map[31] unchanged and freelist_out[1].valid==0.
REQ-028 map[7]==7, retire {ar 7, t 41, told 9} -> told_mismatch 1 next cycle and stays set through later correct retires until reset.
REQ-029 Retire on ways 0 and 2 with reset high -> after the edge map is identity and no free is issued.

Source files
------------

// File: rtl/arch_maptable_pkg.sv
// Shared definitions for the architectural (committed) map table:
// sizing constants, retire/free/recovery packet types and the identity map.
package arch_maptable_pkg;

    localparam int SUPERSCALAR_WAYS = 3;
    localparam int N_ARCH_REG       = 32;
    localparam int N_PHYS_REG_BITS  = 6;
    localparam int ZERO_REG         = 31;
    localparam int AR_IDX_BITS      = $clog2(N_ARCH_REG);

    typedef logic [AR_IDX_BITS-1:0]     ar_idx_t;
    typedef logic [N_PHYS_REG_BITS-1:0] pr_idx_t;

    typedef logic [N_ARCH_REG-1:0][N_PHYS_REG_BITS-1:0] map_t;

    typedef struct packed {
        logic    enable;
        ar_idx_t ar_idx;
        pr_idx_t t_idx;
        pr_idx_t told_idx;
    } retire_maptable_packet_t;

    typedef struct packed {
        logic    valid;
        pr_idx_t pr_idx;
    } freed_reg_packet_t;

    typedef struct packed {
        map_t                  map;
        logic [N_ARCH_REG-1:0] done;
    } maptable_packet_t;

    // Architectural register i maps to physical register i after reset.
    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < N_ARCH_REG; i++) begin
            m[i] = N_PHYS_REG_BITS'(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/arch_maptable_if.sv
// Retire-side bundle of the committed map table: retire ways in, recovery
// map, freed registers and the told-mismatch flag out.
interface arch_maptable_if;
    import arch_maptable_pkg::*;

    retire_maptable_packet_t [SUPERSCALAR_WAYS-1:0] retire_in;
    maptable_packet_t                               recovery_maptable;
    freed_reg_packet_t       [SUPERSCALAR_WAYS-1:0] freelist_out;
    logic                                           told_mismatch;

    // ROB / retire logic side
    modport master (
        output retire_in,
        input  recovery_maptable,
        input  freelist_out,
        input  told_mismatch
    );

    // Map table side
    modport slave (
        input  retire_in,
        output recovery_maptable,
        output freelist_out,
        output told_mismatch
    );

endinterface

// File: rtl/arch_maptable.sv
// Committed (architectural) register map table. Retiring ways update the
// map in way order (youngest wins), release their previous tag to the free
// list and are cross-checked against the committed mapping; any disagreement
// raises a sticky told_mismatch flag.
module arch_maptable
    import arch_maptable_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    arch_maptable_if.slave bus
);

    localparam ar_idx_t ZERO_AR = AR_IDX_BITS'(ZERO_REG);

    map_t                        map_q;
    map_t                        map_d;
    logic                        told_mismatch_q;
    logic                        told_mismatch_d;
    logic [SUPERSCALAR_WAYS-1:0] active;
    pr_idx_t                     told_exp [SUPERSCALAR_WAYS];
    logic                        mismatch_any;

    // A way participates only when enabled and not targeting the zero register.
    always_comb begin
        active = '0;
        for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
            active[i] = bus.retire_in[i].enable &&
                        (bus.retire_in[i].ar_idx != ZERO_AR);
        end
    end

    // Next committed map: apply active writes oldest to youngest so the
    // youngest way targeting a register wins.
    always_comb begin
        map_d = map_q;
        for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
            if (active[i]) begin
                map_d[bus.retire_in[i].ar_idx] = bus.retire_in[i].t_idx;
            end
        end
    end

    // Expected previous tag per way: bypass from the youngest older active way
    // with the same destination, otherwise the committed entry.
    always_comb begin
        mismatch_any = 1'b0;
        for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
            told_exp[i] = map_q[bus.retire_in[i].ar_idx];
            for (int j = 0; j < i; j++) begin
                if (active[j] &&
                    (bus.retire_in[j].ar_idx == bus.retire_in[i].ar_idx)) begin
                    told_exp[i] = bus.retire_in[j].t_idx;
                end
            end
            if (active[i] && (bus.retire_in[i].told_idx != told_exp[i])) begin
                mismatch_any = 1'b1;
            end
        end
        told_mismatch_d = told_mismatch_q | mismatch_any;
    end

    // Outputs: recovery map includes this cycle's retires; reset masks
    // everything back to the identity map with no frees.
    always_comb begin
        bus.recovery_maptable.map  = reset ? identity_map() : map_d;
        bus.recovery_maptable.done = '1;
        for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
            bus.freelist_out[i].valid  = active[i] && !reset;
            bus.freelist_out[i].pr_idx = bus.retire_in[i].told_idx;
        end
        bus.told_mismatch = told_mismatch_q;
    end

    // State register; reset discards any retires presented in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            map_q           <= identity_map();
            told_mismatch_q <= 1'b0;
        end else begin
            map_q           <= map_d;
            told_mismatch_q <= told_mismatch_d;
        end
    end

endmodule

// File: tb/tb_arch_maptable.sv
// Directed bench for arch_maptable with a scoreboard of expected frees and a
// reference committed map maintained by the bench.
module tb_arch_maptable;
    import arch_maptable_pkg::*;

    typedef struct {
        int      way;
        logic    valid;
        pr_idx_t pr;
    } free_exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    map_t model_map;
    free_exp_t free_q[$];

    arch_maptable_if bus ();

    arch_maptable dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One retire cycle. Arguments are packed {way2, way1, way0}.
    task automatic step(input string name, input logic r,
                        input logic [2:0] en, input logic [2:0][4:0] ar,
                        input logic [2:0][5:0] t, input logic [2:0][5:0] told,
                        input logic exp_mm);
        map_t      nxt;
        free_exp_t e;
        logic      act;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
            bus.retire_in[i].enable   = en[i];
            bus.retire_in[i].ar_idx   = ar[i];
            bus.retire_in[i].t_idx    = t[i];
            bus.retire_in[i].told_idx = told[i];
        end
        nxt = model_map;
        for (int i = 0; i < SUPERSCALAR_WAYS; i++) begin
            act = en[i] && (ar[i] != 5'd31) && !r;
            e.way = i; e.valid = act; e.pr = told[i];
            free_q.push_back(e);
            if (act) nxt[ar[i]] = t[i];
        end
        if (r) nxt = identity_map();
        #1;
        while (free_q.size() > 0) begin
            e = free_q.pop_front();
            chk($sformatf("%s free%0d.valid", name, e.way),
                64'(bus.freelist_out[e.way].valid), 64'(e.valid));
            if (e.valid)
                chk($sformatf("%s free%0d.pr", name, e.way),
                    64'(bus.freelist_out[e.way].pr_idx), 64'(e.pr));
        end
        for (int k = 0; k < N_ARCH_REG; k++) begin
            chk($sformatf("%s recov.map[%0d]", name, k),
                64'(bus.recovery_maptable.map[k]), 64'(nxt[k]));
        end
        chk($sformatf("%s recov.done", name),
            64'(bus.recovery_maptable.done), 64'hFFFF_FFFF);
        @(posedge clk);
        #1;
        model_map = nxt;
        chk($sformatf("%s told_mismatch", name), 64'(bus.told_mismatch), 64'(exp_mm));
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        model_map = identity_map();
        bus.retire_in = '0;

        step("rst0", 1'b1, 3'b000, '0, '0, '0, 1'b0);
        step("rst1", 1'b1, 3'b000, '0, '0, '0, 1'b0);

        // way0 {ar 5, t 40, told 5}
        step("w0_ar5", 1'b0, 3'b001, {5'd0, 5'd0, 5'd5},
             {6'd0, 6'd0, 6'd40}, {6'd0, 6'd0, 6'd5}, 1'b0);
        // idle cycle: committed map[5] must now be 40
        step("idle", 1'b0, 3'b000, '0, '0, '0, 1'b0);
        // three ways to ar 3, chained told bypass
        step("chain_ar3", 1'b0, 3'b111, {5'd3, 5'd3, 5'd3},
             {6'd35, 6'd34, 6'd33}, {6'd34, 6'd33, 6'd3}, 1'b0);
        // zero register write on way1 is ignored
        step("zero_reg", 1'b0, 3'b010, {5'd0, 5'd31, 5'd0},
             {6'd0, 6'd50, 6'd0}, {6'd0, 6'd31, 6'd0}, 1'b0);
        // non-contiguous ways: disabled way1 must not enter the bypass chain
        step("gap_ar10", 1'b0, 3'b101, {5'd10, 5'd10, 5'd10},
             {6'd22, 6'd21, 6'd20}, {6'd20, 6'd63, 6'd10}, 1'b0);
        // two different registers, plus way2 on an older-updated register
        step("mixed", 1'b0, 3'b111, {5'd5, 5'd12, 5'd1},
             {6'd44, 6'd43, 6'd42}, {6'd40, 6'd12, 6'd1}, 1'b0);
        // wrong told on ar 7 -> sticky flag
        step("bad_told", 1'b0, 3'b001, {5'd0, 5'd0, 5'd7},
             {6'd0, 6'd0, 6'd41}, {6'd0, 6'd0, 6'd9}, 1'b1);
        step("good_after", 1'b0, 3'b001, {5'd0, 5'd0, 5'd7},
             {6'd0, 6'd0, 6'd45}, {6'd0, 6'd0, 6'd41}, 1'b1);
        step("idle_sticky", 1'b0, 3'b000, '0, '0, '0, 1'b1);
        // reset with retires on ways 0 and 2: discarded, flag cleared
        step("rst_retire", 1'b1, 3'b101, {5'd8, 5'd0, 5'd9},
             {6'd50, 6'd0, 6'd51}, {6'd8, 6'd0, 6'd9}, 1'b0);
        step("post_rst", 1'b0, 3'b000, '0, '0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
